// File: rtl/image_pkg.sv
// Shared pixel types and window-row indices for the 3x3 windowing datapath.
package image_pkg;
    localparam int PIX_W_DEFAULT = 8;

    localparam int WIN_TOP = 0;
    localparam int WIN_MID = 1;
    localparam int WIN_BOT = 2;

    typedef logic [PIX_W_DEFAULT-1:0] pixel_t;
    typedef pixel_t [2:0]             pixel_vec_t;
endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out stream bundle for window_gen_3x3.
// win_last is present only when WIN_LAST_EN is defined.
interface window_gen_3x3_if #(parameter int DATA_W = image_pkg::PIX_W_DEFAULT);
    logic [DATA_W-1:0] in_pixel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic              win_valid;
    logic              win_ready;
`ifdef WIN_LAST_EN
    logic              win_last;
`endif

    modport master (
        output in_pixel, in_valid, win_ready,
`ifdef WIN_LAST_EN
        input  win_last,
`endif
        input  in_ready, win_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9
    );

    modport slave (
        input  in_pixel, in_valid, win_ready,
`ifdef WIN_LAST_EN
        output win_last,
`endif
        output in_ready, win_valid, p1, p2, p3, p4, p5, p6, p7, p8, p9
    );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Two-line buffer: one word per column holding {older line, newer line}.
// Combinational read, synchronous write, so a same-cycle update sees the old contents.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [AW-1:0]       addr,
    input  logic                we,
    input  logic [2*DATA_W-1:0] wr_data,
    output logic [2*DATA_W-1:0] rd_data
);
    logic [2*DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wr_data;
    end
endmodule

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 neighbourhood generator with one-deep output handshake.
// Optional frame-end flag on the final window: define WIN_LAST_EN.
module window_gen_3x3
    import image_pkg::*;
#(
    parameter int DATA_W = PIX_W_DEFAULT,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic            clk,
    input  logic            rst,
    window_gen_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic                         accept, emit, col_end, row_end;
    logic                         win_vld;
    logic [2*DATA_W-1:0]          lb_rd;
    logic [2:0][2:0][DATA_W-1:0]  win;

    assign bus.in_ready = !win_vld || bus.win_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign col_end      = (col == CW'(IMG_W - 1));
    assign row_end      = (row == RW'(IMG_H - 1));
    // Rows 0/1 and columns 0/1 are gated off, so stale lines and wrap garbage never escape.
    assign emit         = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb (
        .clk     (clk),
        .addr    (col),
        .we      (accept),
        .wr_data ({lb_rd[DATA_W-1:0], bus.in_pixel}),
        .rd_data (lb_rd)
    );

    // win[row][col]: column 2 is the newest; the array doubles as the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[WIN_TOP][2] <= lb_rd[2*DATA_W-1:DATA_W];
            win[WIN_MID][2] <= lb_rd[DATA_W-1:0];
            win[WIN_BOT][2] <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                win_vld <= 1'b0;
        else if (accept)        win_vld <= emit;
        else if (bus.win_ready) win_vld <= 1'b0;
    end

`ifdef WIN_LAST_EN
    logic win_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                win_last_q <= 1'b0;
        else if (accept)        win_last_q <= emit && row_end && col_end;
        else if (bus.win_ready) win_last_q <= 1'b0;
    end

    assign bus.win_last = win_last_q;
`endif

    assign bus.win_valid = win_vld;
    assign bus.p1 = win[WIN_TOP][0];
    assign bus.p2 = win[WIN_TOP][1];
    assign bus.p3 = win[WIN_TOP][2];
    assign bus.p4 = win[WIN_MID][0];
    assign bus.p5 = win[WIN_MID][1];
    assign bus.p6 = win[WIN_MID][2];
    assign bus.p7 = win[WIN_BOT][0];
    assign bus.p8 = win[WIN_BOT][1];
    assign bus.p9 = win[WIN_BOT][2];
endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image; windows are logged at handshake time.
module tb_window_gen_3x3;
    localparam int DW = 8;

`ifdef WIN_LAST_EN
    localparam logic LAST_ON = 1'b1;
`else
    localparam logic LAST_ON = 1'b0;
`endif

    localparam logic [71:0] W1  = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    localparam logic [71:0] W2  = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    localparam logic [71:0] W3  = {8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14};
    localparam logic [71:0] W4  = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    localparam logic [71:0] WF2 = {8'd100, 8'd101, 8'd102, 8'd104, 8'd105, 8'd106, 8'd108, 8'd109, 8'd110};
    localparam logic [71:0] A1  = {8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    localparam logic [71:0] A2  = {8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [72:0] q[$];

    always #5 clk = ~clk;

    window_gen_3x3_if #(.DATA_W(DW)) bus ();

    window_gen_3x3 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [71:0] cur_win();
        return {bus.p1, bus.p2, bus.p3, bus.p4, bus.p5, bus.p6, bus.p7, bus.p8, bus.p9};
    endfunction

    function automatic logic cur_last();
`ifdef WIN_LAST_EN
        return bus.win_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive after negedge, log a window if it is consumed at the coming posedge.
    task automatic cyc(input logic v, input logic [7:0] pix, input logic wr, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_pixel  = pix;
        bus.win_ready = wr;
        #1;
        if (bus.win_valid && wr) q.push_back({cur_win(), cur_last()});
        acc = v && bus.in_ready;
        @(posedge clk);
    endtask

    task automatic send(input logic [7:0] pix);
        logic acc = 1'b0;
        int   n   = 0;
        while (!acc && n < 20) begin
            cyc(1'b1, pix, 1'b1, acc);
            n++;
        end
        if (!acc) chk("send_timeout", 80'(acc), 80'(1));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, acc);
    endtask

    task automatic chk_win(input string tag, input int idx, input logic [71:0] w, input logic l);
        chk(tag, 80'(q[idx][72:1]), 80'(w));
        chk({tag, "_last"}, 80'(q[idx][0]), 80'(l));
    endtask

    task automatic chk_frame(input string tag, input int off);
        chk_win({tag, "_w1"}, off + 0, W1, 1'b0);
        chk_win({tag, "_w2"}, off + 1, W2, 1'b0);
        chk_win({tag, "_w3"}, off + 2, W3, 1'b0);
        chk_win({tag, "_w4"}, off + 3, W4, LAST_ON);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.win_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 80'(bus.win_valid), 80'(0));
        chk("rst_win",   80'(cur_win()),     80'(0));
        chk("rst_last",  80'(cur_last()),    80'(0));
        chk("rst_ready", 80'(bus.in_ready),  80'(1));

        // Full-rate frame.
        for (int k = 0; k < 16; k++) send(8'(k));
        idle(2);
        chk("t1_count", 80'(q.size()), 80'(4));
        chk_frame("t1", 0);
        q.delete();

        // Back-pressure on the first window.
        for (int k = 0; k < 11; k++) send(8'(k));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_pixel  = 8'd11;
            bus.win_ready = 1'b0;
            #1;
            chk("t2_hold_win",   80'(cur_win()),     80'(W1));
            chk("t2_hold_valid", 80'(bus.win_valid), 80'(1));
            chk("t2_hold_ready", 80'(bus.in_ready),  80'(0));
            @(posedge clk);
        end
        for (int k = 11; k < 16; k++) send(8'(k));
        idle(2);
        chk("t2_count", 80'(q.size()), 80'(4));
        chk_frame("t2", 0);
        q.delete();

        // Random input gaps.
        for (int k = 0; k < 16; k++) begin
            for (int g = 0; g < 6 && $urandom_range(1, 0) == 1; g++) idle(1);
            send(8'(k));
        end
        idle(2);
        chk("t3_count", 80'(q.size()), 80'(4));
        chk_frame("t3", 0);
        q.delete();

        // Back-to-back frames.
        for (int k = 0; k < 16; k++) send(8'(k));
        for (int k = 0; k < 16; k++) send(8'(100 + k));
        idle(2);
        chk("t4_count", 80'(q.size()), 80'(8));
        chk_frame("t4a", 0);
        chk_win("t4b_w1", 4, WF2, 1'b0);
        chk("t4b_w4_last", 80'(q[7][0]), 80'(LAST_ON));
        q.delete();

        // Reset mid-frame.
        for (int k = 0; k < 10; k++) send(8'(k));
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_in_rst", 80'(bus.win_valid), 80'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_after_rst", 80'(bus.win_valid), 80'(0));
        q.delete();
        for (int k = 0; k < 16; k++) send(8'(k));
        idle(2);
        chk("t5_count", 80'(q.size()), 80'(4));
        chk_frame("t5", 0);
        q.delete();

        // Full-scale alternating values.
        for (int k = 0; k < 16; k++) send((k % 2 == 0) ? 8'hFF : 8'h00);
        idle(2);
        chk("t6_count", 80'(q.size()), 80'(4));
        chk_win("t6_w1", 0, A1, 1'b0);
        chk_win("t6_w2", 1, A2, 1'b0);
        chk_win("t6_w3", 2, A1, 1'b0);
        chk_win("t6_w4", 3, A2, LAST_ON);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
